// File: rtl/food_consumer.sv
// -----------------------------------------------------------------------------
// food_consumer
//
// Food-side game logic for a snake game. It latches a food position from the
// food generator, watches for the snake head landing on it on each game tick,
// pulses eaten/grow_req, keeps a four-digit BCD score and waits a short settle
// period before accepting the next food candidate.
//
// Parameters
//   BLOCK   cell size in pixels; head and food overlap when both axis
//           distances are below BLOCK
//   SETTLE  cycles spent between an eat and the next candidate fetch
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   clear        synchronous restart, same effect as rst
//   tick         one-cycle game-step strobe; eats are only detected on tick
//   x_head/y_head  snake head pixel coordinates (10 bits)
//   x_cand/y_cand  candidate food coordinates (10 bits)
//   cand_ok      candidate lies inside the playfield margin
//   x_food/y_food  latched food position (10 bits)
//   food_active  food position valid and displayed
//   eaten        one-cycle pulse on an eat
//   grow_req     one-cycle pulse coincident with eaten
//   score        four BCD digits, score[3:0] is the units digit
// -----------------------------------------------------------------------------
module food_consumer #(
    parameter int BLOCK  = 8,
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        tick,
    input  logic [9:0]  x_head,
    input  logic [9:0]  y_head,
    input  logic [9:0]  x_cand,
    input  logic [9:0]  y_cand,
    input  logic        cand_ok,
    output logic [9:0]  x_food,
    output logic [9:0]  y_food,
    output logic        food_active,
    output logic        eaten,
    output logic        grow_req,
    output logic [15:0] score
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_ACTIVE,
        ST_SETTLE
    } state_t;

    state_t        state_reg,   state_next;
    logic [9:0]    x_food_reg,  x_food_next;
    logic [9:0]    y_food_reg,  y_food_next;
    logic          active_reg,  active_next;
    logic          eaten_reg,   eaten_next;
    logic          grow_reg,    grow_next;
    logic [15:0]   score_reg,   score_next;
    logic [CW-1:0] cnt_reg,     cnt_next;

    // Distance test on one axis. The difference is taken in 11 bits with the
    // operands ordered so the result is the true magnitude; no wrap-around.
    function automatic logic axis_near(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, b} - {1'b0, a};
        return d < 11'(BLOCK);
    endfunction

    logic cand_clear;   // candidate does not sit on the head
    logic head_hit;     // head overlaps the active food

    assign cand_clear = ~(axis_near(x_head, x_cand) & axis_near(y_head, y_cand));
    assign head_hit   = axis_near(x_head, x_food_reg) & axis_near(y_head, y_food_reg);

    // BCD increment as a ripple of per-digit carries: a digit advances when
    // every lower digit is 9, and a 9 that advances wraps to 0.
    logic [15:0] score_inc;
    logic [3:0]  carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] digit;
            assign digit = score_reg[gi*4 +: 4];
            assign score_inc[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                                    : digit;
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit == 4'd9);
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        x_food_next = x_food_reg;
        y_food_next = y_food_reg;
        active_next = active_reg;
        eaten_next  = 1'b0;
        grow_next   = 1'b0;
        score_next  = score_reg;
        cnt_next    = cnt_reg;

        if (clear) begin
            // Restart takes priority over everything, including a tick.
            state_next  = ST_FETCH;
            x_food_next = '0;
            y_food_next = '0;
            active_next = 1'b0;
            score_next  = '0;
            cnt_next    = '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    active_next = 1'b0;
                    if (cand_ok && cand_clear) begin
                        x_food_next = x_cand;
                        y_food_next = y_cand;
                        active_next = 1'b1;
                        state_next  = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (tick && head_hit) begin
                        eaten_next  = 1'b1;
                        grow_next   = 1'b1;
                        active_next = 1'b0;
                        // Score sticks at 9999; the eat still pulses.
                        if (score_reg != 16'h9999)
                            score_next = score_inc;
                        cnt_next    = CW'(SETTLE - 1);
                        state_next  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0)
                        state_next = ST_FETCH;
                    else
                        cnt_next = cnt_reg - CW'(1);
                end
                default: begin
                    state_next  = ST_FETCH;
                    active_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_FETCH;
            x_food_reg <= '0;
            y_food_reg <= '0;
            active_reg <= 1'b0;
            eaten_reg  <= 1'b0;
            grow_reg   <= 1'b0;
            score_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            x_food_reg <= x_food_next;
            y_food_reg <= y_food_next;
            active_reg <= active_next;
            eaten_reg  <= eaten_next;
            grow_reg   <= grow_next;
            score_reg  <= score_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign x_food      = x_food_reg;
    assign y_food      = y_food_reg;
    assign food_active = active_reg;
    assign eaten       = eaten_reg;
    assign grow_req    = grow_reg;
    assign score       = score_reg;

endmodule

// File: tb/tb_food_consumer.sv
// -----------------------------------------------------------------------------
// tb_food_consumer
//
// Scoreboard bench for food_consumer. Stimulus pushes the expected fetch/eat
// events into a queue; a monitor on the falling edge pops an entry whenever the
// DUT shows a food_active rise or an eaten pulse and compares it. Directed
// checks cover reset, near misses, rejection, clear and reset mid-settle; a
// long run drives the score through 0099->0100 and into 9999 saturation.
// -----------------------------------------------------------------------------
module tb_food_consumer;

    logic        clk = 1'b0;
    logic        rst, clear, tick, cand_ok;
    logic [9:0]  x_head, y_head, x_cand, y_cand;
    logic [9:0]  x_food, y_food;
    logic        food_active, eaten, grow_req;
    logic [15:0] score;

    food_consumer #(.BLOCK(8), .SETTLE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .tick        (tick),
        .x_head      (x_head),
        .y_head      (y_head),
        .x_cand      (x_cand),
        .y_cand      (y_cand),
        .cand_ok     (cand_ok),
        .x_food      (x_food),
        .y_food      (y_food),
        .food_active (food_active),
        .eaten       (eaten),
        .grow_req    (grow_req),
        .score       (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_eat;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] score;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   ev_seen = 0;
    bit   verbose = 1'b1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic exp_t mk_fetch(input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        e.is_eat = 1'b0; e.x = x; e.y = y; e.score = '0;
        return e;
    endfunction

    function automatic exp_t mk_eat(input logic [15:0] s);
        exp_t e;
        e.is_eat = 1'b1; e.x = '0; e.y = '0; e.score = s;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Bounded wait for the monitor to have consumed `target` events.
    task automatic wait_events(input int target, input int max_cyc, input string name);
        int c = 0;
        while (ev_seen < target && c < max_cyc) begin
            step();
            c++;
        end
        check(name, 16'(ev_seen), 16'(target));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin : monitor
        exp_t e;
        logic fa_prev;
        fa_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (eaten) begin
                    if (q.size() == 0 || !q[0].is_eat) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_eat: got eaten=1 score=%h expected no eat", score);
                    end else begin
                        e = q.pop_front();
                        check("eat_score", score, e.score);
                        check("eat_grow", {15'b0, grow_req}, 16'h0001);
                        check("eat_active", {15'b0, food_active}, 16'h0000);
                        ev_seen++;
                        if (verbose || score == 16'h0099 || score == 16'h0100 || score == 16'h9999)
                            $display("eat   : score=%h grow_req=%b", score, grow_req);
                    end
                end
                if (food_active && !fa_prev) begin
                    if (q.size() == 0 || q[0].is_eat) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_fetch: got food (%0d,%0d) expected no fetch", x_food, y_food);
                    end else begin
                        e = q.pop_front();
                        check("fetch_x", {6'b0, x_food}, {6'b0, e.x});
                        check("fetch_y", {6'b0, y_food}, {6'b0, e.y});
                        ev_seen++;
                        if (verbose)
                            $display("fetch : food=(%0d,%0d)", x_food, y_food);
                    end
                end
            end
            fa_prev = food_active;
        end
    end

    initial begin : stimulus
        int target;
        int c;

        rst = 1'b1; clear = 1'b0; tick = 1'b0; cand_ok = 1'b0;
        x_head = 10'd600; y_head = 10'd600; x_cand = '0; y_cand = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_x_food", {6'b0, x_food}, 16'h0000);
        check("rst_y_food", {6'b0, y_food}, 16'h0000);
        check("rst_active", {15'b0, food_active}, 16'h0000);
        check("rst_eaten", {15'b0, eaten}, 16'h0000);
        check("rst_grow", {15'b0, grow_req}, 16'h0000);
        check("rst_score", score, 16'h0000);
        rst = 1'b0;

        // Fetch with head well away from the candidate.
        x_head = 10'd300; y_head = 10'd300;
        x_cand = 10'd100; y_cand = 10'd200; cand_ok = 1'b1;
        q.push_back(mk_fetch(10'd100, 10'd200));
        wait_events(1, 5, "fetch_wait");
        cand_ok = 1'b0;

        // Near misses on each axis: distance exactly BLOCK.
        x_head = 10'd108; y_head = 10'd200; tick = 1'b1;
        step(); tick = 1'b0; step(); step();
        check("near_x_score", score, 16'h0000);
        check("near_x_active", {15'b0, food_active}, 16'h0001);
        x_head = 10'd100; y_head = 10'd192; tick = 1'b1;
        step(); tick = 1'b0; step(); step();
        check("near_y_score", score, 16'h0000);

        // Eat, then confirm no refetch during the settle window.
        q.push_back(mk_eat(16'h0001));
        x_head = 10'd105; y_head = 10'd195; tick = 1'b1;
        step();
        tick = 1'b0; x_head = 10'd600; y_head = 10'd600;
        x_cand = 10'd300; y_cand = 10'd40; cand_ok = 1'b1;
        q.push_back(mk_fetch(10'd300, 10'd40));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("settle_no_fetch", {15'b0, food_active}, 16'h0000);
            if (i == 1)
                check("eat_one_cycle", {15'b0, eaten}, 16'h0000);
        end
        wait_events(3, 10, "refetch_wait");
        cand_ok = 1'b0;

        // Clear behaves as a synchronous reset.
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_score", score, 16'h0000);
        check("clear_active", {15'b0, food_active}, 16'h0000);
        check("clear_x_food", {6'b0, x_food}, 16'h0000);

        // Rejection in FETCH (ticks here must not eat).
        x_cand = 10'd50; y_cand = 10'd60; cand_ok = 1'b0; tick = 1'b1;
        repeat (3) step();
        check("reject_candok", {15'b0, food_active}, 16'h0000);
        cand_ok = 1'b1; x_head = 10'd50; y_head = 10'd60;
        repeat (3) step();
        check("reject_on_head", {15'b0, food_active}, 16'h0000);
        tick = 1'b0; x_head = 10'd600; y_head = 10'd600;
        q.push_back(mk_fetch(10'd50, 10'd60));
        wait_events(4, 5, "accept_wait");
        cand_ok = 1'b0;

        // Tick and clear together: clear wins, no pulse, no increment.
        x_head = 10'd50; y_head = 10'd60; tick = 1'b1; clear = 1'b1;
        step();
        tick = 1'b0; clear = 1'b0; x_head = 10'd600; y_head = 10'd600;
        check("clr_tick_eaten", {15'b0, eaten}, 16'h0000);
        check("clr_tick_score", score, 16'h0000);
        check("clr_tick_active", {15'b0, food_active}, 16'h0000);
        step();
        check("clr_tick_eaten2", {15'b0, eaten}, 16'h0000);

        // Reset asserted during SETTLE.
        x_cand = 10'd700; y_cand = 10'd800; cand_ok = 1'b1;
        q.push_back(mk_fetch(10'd700, 10'd800));
        wait_events(5, 5, "fetch2_wait");
        cand_ok = 1'b0;
        q.push_back(mk_eat(16'h0001));
        x_head = 10'd707; y_head = 10'd793; tick = 1'b1;
        step();
        tick = 1'b0; x_head = 10'd600; y_head = 10'd600;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_x_food", {6'b0, x_food}, 16'h0000);
        check("mid_rst_y_food", {6'b0, y_food}, 16'h0000);
        check("mid_rst_active", {15'b0, food_active}, 16'h0000);
        check("mid_rst_eaten", {15'b0, eaten}, 16'h0000);
        check("mid_rst_grow", {15'b0, grow_req}, 16'h0000);
        check("mid_rst_score", score, 16'h0000);
        step(); step();
        rst = 1'b0;
        wait_events(6, 1, "eat_before_rst");
        x_cand = 10'd10; y_cand = 10'd20; cand_ok = 1'b1;
        q.push_back(mk_fetch(10'd10, 10'd20));
        wait_events(7, 5, "fetch_after_rst");

        // Long run: 10000 eats, crossing 0099->0100 and saturating at 9999.
        verbose = 1'b0;
        x_cand = 10'd100; y_cand = 10'd200; cand_ok = 1'b1; tick = 1'b1;
        for (int k = 1; k <= 10000; k++) begin
            q.push_back(mk_eat(to_bcd((k > 9999) ? 9999 : k)));
            q.push_back(mk_fetch(10'd100, 10'd200));
        end
        target = 7 + 20000;
        c = 0;
        while (ev_seen < target && c < 70000) begin
            if (food_active) begin
                x_head = x_food; y_head = y_food;
            end else begin
                x_head = 10'd600; y_head = 10'd600;
            end
            step();
            c++;
        end
        tick = 1'b0;
        check("bulk_events", 16'(ev_seen), 16'(target));
        check("final_score", score, 16'h9999);
        check("queue_empty", 16'(q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
